// File: rtl/wait_ram.sv
// wait_ram: single-port 32-bit word RAM with programmable read/write wait states.
// Optional RAM_STATS_EN adds rd_count/wr_count access counters.
//
// Parameters:
//   ADDR_WIDTH    word-address bits, DEPTH = 2**ADDR_WIDTH words
//   READ_LATENCY  edges from accepted read to rdata valid (0..15)
//   WRITE_LATENCY edges from accepted write to array update (0..15)
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   addr           byte address, word index addr[ADDR_WIDTH+1:2]
//   wmask, wdata   byte-lane write enables and write data
//   rstrb, wstrb   read / write requests, sampled only when idle
//   rdata          read data, held between reads
//   rbusy, wbusy   read / write in progress
//   rd_count,      accepted read / write counters
//   wr_count       (present only with RAM_STATS_EN)
module wait_ram #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 0,
    parameter int WRITE_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic        rstrb,
    input  logic        wstrb,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        wbusy
`ifdef RAM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] RL_M1 =
        4'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);
    localparam logic [3:0] WL_M1 =
        4'(WRITE_LATENCY > 0 ? WRITE_LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        WR_THEN_RD
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;
    logic [31:0]           mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  we;
    logic [ADDR_WIDTH-1:0] we_addr;
    logic [31:0]           we_data;
    logic [3:0]            we_mask;
    logic [31:0]           post_wr;
    logic                  unused_addr_bits;

    assign idx = addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] data,
                                          input logic [3:0]  m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    // A write lands either immediately from the live inputs (zero write
    // latency) or from the latched request when the write countdown expires.
    always_comb begin
        we      = 1'b0;
        we_addr = idx;
        we_data = wdata;
        we_mask = wmask;
        unique case (state_q)
            IDLE: we = wstrb && (WRITE_LATENCY == 0);
            WR_WAIT, WR_THEN_RD: begin
                we      = (cnt_q == 4'd0);
                we_addr = addr_q;
                we_data = wdata_q;
                we_mask = wmask_q;
            end
            default: we = 1'b0;
        endcase
        if (rst) we = 1'b0;
    end

    // Word as it looks after the pending write; used for read-after-write.
    assign post_wr = merge(mem_q[we_addr], we_data, we_mask);

    // No reset on the array: contents survive rst.
    always_ff @(posedge clk) begin
        if (we) mem_q[we_addr] <= post_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            wmask_q  <= 4'd0;
            rdata    <= 32'd0;
            rbusy    <= 1'b0;
            wbusy    <= 1'b0;
`ifdef RAM_STATS_EN
            rd_count <= 32'd0;
            wr_count <= 32'd0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
`ifdef RAM_STATS_EN
                    if (rstrb) rd_count <= rd_count + 32'd1;
                    if (wstrb) wr_count <= wr_count + 32'd1;
`endif
                    if (rstrb || wstrb) addr_q <= idx;
                    if (wstrb) begin
                        wdata_q <= wdata;
                        wmask_q <= wmask;
                    end
                    if (wstrb && WRITE_LATENCY != 0) begin
                        wbusy   <= 1'b1;
                        rbusy   <= rstrb;
                        cnt_q   <= WL_M1;
                        state_q <= rstrb ? WR_THEN_RD : WR_WAIT;
                    end else if (rstrb && READ_LATENCY != 0) begin
                        rbusy   <= 1'b1;
                        cnt_q   <= RL_M1;
                        state_q <= RD_WAIT;
                    end else if (rstrb) begin
                        rdata <= wstrb ? post_wr : mem_q[idx];
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        wbusy   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_THEN_RD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (READ_LATENCY == 0) begin
                        wbusy   <= 1'b0;
                        rbusy   <= 1'b0;
                        rdata   <= post_wr;
                        state_q <= IDLE;
                    end else begin
                        // Write done; the read wait starts now.
                        wbusy   <= 1'b0;
                        cnt_q   <= RL_M1;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata   <= mem_q[addr_q];
                        rbusy   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wait_ram.sv
// tb_wait_ram: directed checks of wait_ram in four latency configurations.
// u0: L0/W0, u1: L3/W0, u2: L1/W2, u3: L0/W4.
module tb_wait_ram;

    logic        clk;
    logic [3:0]  rst_v;
    logic [31:0] addr_v  [4];
    logic [3:0]  wmask_v [4];
    logic [31:0] wdata_v [4];
    logic [3:0]  rstrb_v;
    logic [3:0]  wstrb_v;
    logic [31:0] rdata_v [4];
    logic        rbusy_v [4];
    logic        wbusy_v [4];
`ifdef RAM_STATS_EN
    logic [31:0] rdc_v [4];
    logic [31:0] wrc_v [4];
`endif

    int n_vec;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RAM_STATS_EN
    `define STATS_PORTS(i) , .rd_count(rdc_v[i]), .wr_count(wrc_v[i])
`else
    `define STATS_PORTS(i)
`endif

    wait_ram #(.ADDR_WIDTH(10), .READ_LATENCY(0), .WRITE_LATENCY(0)) u0 (
        .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .wmask(wmask_v[0]),
        .wdata(wdata_v[0]), .rstrb(rstrb_v[0]), .wstrb(wstrb_v[0]),
        .rdata(rdata_v[0]), .rbusy(rbusy_v[0]), .wbusy(wbusy_v[0])
        `STATS_PORTS(0)
    );
    wait_ram #(.ADDR_WIDTH(10), .READ_LATENCY(3), .WRITE_LATENCY(0)) u1 (
        .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .wmask(wmask_v[1]),
        .wdata(wdata_v[1]), .rstrb(rstrb_v[1]), .wstrb(wstrb_v[1]),
        .rdata(rdata_v[1]), .rbusy(rbusy_v[1]), .wbusy(wbusy_v[1])
        `STATS_PORTS(1)
    );
    wait_ram #(.ADDR_WIDTH(10), .READ_LATENCY(1), .WRITE_LATENCY(2)) u2 (
        .clk(clk), .rst(rst_v[2]), .addr(addr_v[2]), .wmask(wmask_v[2]),
        .wdata(wdata_v[2]), .rstrb(rstrb_v[2]), .wstrb(wstrb_v[2]),
        .rdata(rdata_v[2]), .rbusy(rbusy_v[2]), .wbusy(wbusy_v[2])
        `STATS_PORTS(2)
    );
    wait_ram #(.ADDR_WIDTH(10), .READ_LATENCY(0), .WRITE_LATENCY(4)) u3 (
        .clk(clk), .rst(rst_v[3]), .addr(addr_v[3]), .wmask(wmask_v[3]),
        .wdata(wdata_v[3]), .rstrb(rstrb_v[3]), .wstrb(wstrb_v[3]),
        .rdata(rdata_v[3]), .rbusy(rbusy_v[3]), .wbusy(wbusy_v[3])
        `STATS_PORTS(3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request, returns 1ns after the accepting edge E0.
    task automatic op(input int d, input logic [31:0] a,
                      input logic [31:0] data, input logic [3:0] m,
                      input logic do_r, input logic do_w);
        addr_v[d]  = a;
        wdata_v[d] = data;
        wmask_v[d] = m;
        rstrb_v[d] = do_r;
        wstrb_v[d] = do_w;
        @(posedge clk);
        #1;
        rstrb_v[d] = 1'b0;
        wstrb_v[d] = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst_v   = 4'hF;
        rstrb_v = 4'h0;
        wstrb_v = 4'h0;
        for (int i = 0; i < 4; i++) begin
            addr_v[i]  = 32'd0;
            wdata_v[i] = 32'd0;
            wmask_v[i] = 4'd0;
        end
        tick(2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rdata%0d", i), rdata_v[i], 32'd0);
            check($sformatf("rst_rbusy%0d", i), 32'(rbusy_v[i]), 32'd0);
            check($sformatf("rst_wbusy%0d", i), 32'(wbusy_v[i]), 32'd0);
        end
        rst_v = 4'h0;
        tick(1);

        // u0: zero-latency behaviour
        op(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        check("l0_wbusy", 32'(wbusy_v[0]), 32'd0);
        op(0, 32'h10, 32'd0, 4'h0, 1'b1, 1'b0);
        check("l0_rdata", rdata_v[0], 32'hDEADBEEF);
        check("l0_rbusy", 32'(rbusy_v[0]), 32'd0);
        op(0, 32'h14, 32'h11223344, 4'hF, 1'b0, 1'b1);
        op(0, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b1);
        op(0, 32'h14, 32'd0, 4'h0, 1'b1, 1'b0);
        check("l0_mask", rdata_v[0], 32'h11BB33DD);
        op(0, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1);
        op(0, 32'h1010, 32'd0, 4'h0, 1'b1, 1'b0);
        check("l0_mask0_alias", rdata_v[0], 32'hDEADBEEF);
        op(0, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b1);
        check("l0_simul", rdata_v[0], 32'h12345678);
        tick(3);
        check("l0_hold", rdata_v[0], 32'h12345678);

        // u1: READ_LATENCY=3, with an ignored mid-wait strobe
        op(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        op(1, 32'h10, 32'd0, 4'h0, 1'b1, 1'b0);
        check("l3_rbusy_e0", 32'(rbusy_v[1]), 32'd1);
        op(1, 32'h14, 32'd0, 4'h0, 1'b1, 1'b0);
        check("l3_rbusy_e1", 32'(rbusy_v[1]), 32'd1);
        tick(1);
        check("l3_rbusy_e2", 32'(rbusy_v[1]), 32'd1);
        check("l3_rdata_e2", rdata_v[1], 32'd0);
        tick(1);
        check("l3_rbusy_e3", 32'(rbusy_v[1]), 32'd0);
        check("l3_rdata_e3", rdata_v[1], 32'hDEADBEEF);
        tick(1);
        check("l3_ignored", 32'(rbusy_v[1]), 32'd0);

        // u2: WRITE_LATENCY=2, READ_LATENCY=1
        op(2, 32'h14, 32'h11223344, 4'hF, 1'b0, 1'b1);
        check("w2_wbusy_e0", 32'(wbusy_v[2]), 32'd1);
        tick(1);
        check("w2_wbusy_e1", 32'(wbusy_v[2]), 32'd1);
        tick(1);
        check("w2_wbusy_e2", 32'(wbusy_v[2]), 32'd0);
        op(2, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b1);
        tick(2);
        op(2, 32'h14, 32'd0, 4'h0, 1'b1, 1'b0);
        check("w2_rbusy_e0", 32'(rbusy_v[2]), 32'd1);
        tick(1);
        check("w2_mask", rdata_v[2], 32'h11BB33DD);
        op(2, 32'h18, 32'h0000CAFE, 4'hF, 1'b1, 1'b1);
        check("sim_wbusy_e0", 32'(wbusy_v[2]), 32'd1);
        check("sim_rbusy_e0", 32'(rbusy_v[2]), 32'd1);
        tick(1);
        check("sim_wbusy_e1", 32'(wbusy_v[2]), 32'd1);
        tick(1);
        check("sim_wbusy_e2", 32'(wbusy_v[2]), 32'd0);
        check("sim_rbusy_e2", 32'(rbusy_v[2]), 32'd1);
        tick(1);
        check("sim_rbusy_e3", 32'(rbusy_v[2]), 32'd0);
        check("sim_rdata", rdata_v[2], 32'h0000CAFE);

        // u3: WRITE_LATENCY=4, reset drops the in-flight write
        op(3, 32'h30, 32'h55AA55AA, 4'hF, 1'b0, 1'b1);
        tick(4);
        check("w4_done", 32'(wbusy_v[3]), 32'd0);
        op(3, 32'h30, 32'h01020304, 4'hF, 1'b0, 1'b1);
        tick(2);
        check("w4_busy_e2", 32'(wbusy_v[3]), 32'd1);
        rst_v[3] = 1'b1;
        #1;
        check("w4_rst_wbusy", 32'(wbusy_v[3]), 32'd0);
        tick(3);
        rst_v[3] = 1'b0;
        tick(1);
        op(3, 32'h30, 32'd0, 4'h0, 1'b1, 1'b0);
        check("w4_old_word", rdata_v[3], 32'h55AA55AA);

        // u0: array survives reset, aliasing, access counters
        rst_v[0] = 1'b1;
        tick(1);
        check("r_rdata_clr", rdata_v[0], 32'd0);
`ifdef RAM_STATS_EN
        check("r_rdc_clr", rdc_v[0], 32'd0);
        check("r_wrc_clr", wrc_v[0], 32'd0);
`endif
        rst_v[0] = 1'b0;
        tick(1);
        op(0, 32'h10, 32'd0, 4'h0, 1'b1, 1'b0);
        check("r_keep", rdata_v[0], 32'hDEADBEEF);
        op(0, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 1'b1);
        op(0, 32'h1000, 32'd0, 4'h0, 1'b1, 1'b0);
        check("alias_1000", rdata_v[0], 32'h0BADF00D);
        op(0, 32'h14, 32'h87654321, 4'hF, 1'b0, 1'b1);
        op(0, 32'h14, 32'd0, 4'h0, 1'b1, 1'b0);
        check("r_rd14", rdata_v[0], 32'h87654321);
        op(0, 32'h24, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b1);
        check("r_simul", rdata_v[0], 32'hA5A5A5A5);
`ifdef RAM_STATS_EN
        check("rd_count", rdc_v[0], 32'd4);
        check("wr_count", wrc_v[0], 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wait_ram.md
WAIT_RAM -- requirements
Module: wait_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 0, meaning cycles from accepted read to rdata valid (0..15).
REQ-003 SHALL have parameter WRITE_LATENCY, default 0, meaning cycles from accepted write to array update (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports addr input 32 byte address; wmask input 4 byte-lane write enables; wdata input 32 write data.
REQ-007 SHALL have ports rstrb input 1 read request; wstrb input 1 write request.
REQ-008 SHALL have ports rdata output 32 read data; rbusy output 1 read in progress; wbusy output 1 write in progress.
REQ-009 SHALL have ports rd_count output 32 and wr_count output 32 only when RAM_STATS_EN is defined.

Function
REQ-010 SHALL index the array with addr[ADDR_WIDTH+1:2]; upper address bits ignored (wrap modulo DEPTH).
REQ-011 SHALL implement states IDLE, RD_WAIT, WR_WAIT, WR_THEN_RD; strobes sampled only in IDLE, ignored otherwise.
REQ-012 SHALL, for a read accepted at edge E0 with READ_LATENCY=0, load rdata at E0, stay IDLE, never assert rbusy.
REQ-013 SHALL, for READ_LATENCY=L>0, latch addr at E0, enter RD_WAIT, drive rbusy=1 from E0 through E0+L, load rdata and clear rbusy at E0+L, return to IDLE.
REQ-014 SHALL, for WRITE_LATENCY=0, update enabled byte lanes at E0, never assert wbusy.
REQ-015 SHALL, for WRITE_LATENCY=W>0, latch addr/wdata/wmask at E0, enter WR_WAIT, wbusy=1 through E0+W, update array and clear wbusy at E0+W.
REQ-016 SHALL write only lanes with wmask bit set; wmask=0 with wstrb SHALL complete normally but change nothing.
REQ-017 SHALL, on rstrb and wstrb together in IDLE, accept both: write first, read address latched, rbusy and wbusy=1 from E0 (if W>0), read latency counted after write completes; rdata reflects post-write data.
REQ-018 SHALL, with both latencies 0 and simultaneous strobes, update array and return post-write data at E0.
REQ-019 SHALL hold rdata between reads.
REQ-020 SHALL use a single 4-bit down-counter for both wait phases.

Reset
REQ-021 SHALL on rst: state IDLE, rbusy=0, wbusy=0, rdata=0, counter 0, rd_count=0, wr_count=0.
REQ-022 SHALL NOT clear array contents on reset.
REQ-023 SHALL drop an in-flight write on reset mid-operation (array unchanged) and abandon pending reads.

Configuration
REQ-024 SHALL, when RAM_STATS_EN is defined, increment rd_count per accepted read and wr_count per accepted write, wrapping at 2**32, both incrementing on simultaneous strobes.
REQ-025 SHALL, when RAM_STATS_EN is undefined, omit counters and ports; all other behaviour identical.

Verification
REQ-026 L=0,W=0: write 0xDEADBEEF mask 4'hF to 0x10, then read 0x10 -> rdata=0xDEADBEEF the edge after rstrb, rbusy/wbusy never high.
REQ-027 READ_LATENCY=3: read 0x10 at E0 -> rbusy high E0..E0+3, rdata=0xDEADBEEF at E0+3; rstrb pulsed at E0+1 ignored.
REQ-028 WRITE_LATENCY=2: word 0x11223344, write 0xAABBCCDD mask 4'b0101 -> wbusy 2 cycles, readback 0x11BB33DD.
REQ-029 W=2,L=1 simultaneous write 0x0000CAFE and read same address -> wbusy clears E0+2, rbusy clears E0+3, rdata=0x0000CAFE.
REQ-030 W=4: assert rst at E0+2 during write -> wbusy=0 immediately, readback returns old word.
REQ-031 RAM_STATS_EN: 3 reads, 2 writes, 1 simultaneous pair -> rd_count=4, wr_count=3; addr 0x1000 with ADDR_WIDTH=10 aliases 0x0000.
